dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory.
- Port A is the CPU load/store stage; port B is the DMA/debug loader.
- Selects one access per cycle and drives the memory's Address, WriteData, MemWrite and MemRead as registered outputs.
- Returns read data to the owning requester with a valid strobe.

Parameters:
- DATA_WIDTH, 8, data word width; matches the memory's DATA_WIDTH.
- DATA_DIR_WIDTH, 8, address width; matches the memory's DATA_DIR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req  in  1  A access request.
- a_we  in  1  A write (1) / read (0).
- a_addr  in  DATA_DIR_WIDTH  A address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_gnt  out  1  A command accepted; one-cycle pulse.
- a_rvalid  out  1  A read data valid; one-cycle pulse.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid: same as the A ports, for B.
- rdata  out  DATA_WIDTH  read data; qualify with a_rvalid or b_rvalid.
- mem_addr  out  DATA_DIR_WIDTH  connects to memory Address.
- mem_wdata  out  DATA_WIDTH  connects to memory WriteData.
- mem_write  out  1  connects to memory MemWrite.
- mem_read  out  1  connects to memory MemRead.
- mem_rdata  in  DATA_WIDTH  connects from memory ReadData.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0; rdata is 0.
  - Round-robin pointer last_owner=B, so A wins the first contest.
  - Pipeline state returns to IDLE.
  - A reset mid-operation drops any in-flight command and rvalid; no gnt or rvalid appears after reset releases until a new request arrives.
- Eligibility: a requester is eligible at a clk edge if req=1 and its gnt is not high in the current cycle. The cycle in which gnt is high consumes the request.
- Arbitration at each rising clk edge:
  - Only one requester eligible: it wins.
  - Both eligible: winner is the one that is not last_owner; last_owner then updates to the winner.
  - No requester eligible: issue state goes to IDLE; mem_write=mem_read=0; mem_addr and mem_wdata hold their previous values.
- Issue (registered), in the cycle after the arbitration edge (state ISSUE_A or ISSUE_B):
  - mem_addr, mem_wdata and the winner's gnt are driven.
  - mem_write=we or mem_read=~we; never both.
- Requester hold rule: req, we, addr and wdata stay stable from req rise until the cycle gnt is high. They may change at the edge that ends the gnt cycle.
- Read return:
  - The memory samples the command at the edge ending the ISSUE cycle.
  - In the following cycle, owner's rvalid=1 and rdata=mem_rdata.
  - Total read latency is 2 cycles from the arbitration edge to rvalid.
  - rvalid follows the owner that issued the read, even if the next issue belongs to the other port.
- Writes produce no rvalid; write completion equals gnt.
- Throughput:
  - One memory command per cycle when the ports alternate.
  - A single port that holds req continuously is granted every second cycle.
- No starvation: under continuous contention, grants strictly alternate A,B,A,B.
- Address width: an address is passed unmodified; no range checking (the memory wraps or ignores out-of-depth indices).
- Simultaneous events: a rvalid for the previous read and a gnt for a new command in the same cycle is legal and required for back-to-back operation.

Optional Feature:
- Macro DMEM_ARB_LOCK_EN adds input b_lock (1 bit), sampled with b_req.
- With the macro defined:
  - When B is granted with b_lock=1, a lock flag is set.
  - While locked, A is ineligible. B gets back-to-back-eligible grants; the "gnt consumes" rule still applies, so B is granted every second cycle.
  - The lock clears when B is granted with b_lock=0, or at any edge where b_req=0 during a non-gnt cycle.
  - Reset clears the lock.
- Without the macro: no b_lock port; pure round-robin as above.

Test Plan:
- Reset, then A read addr 0x03 with the memory preloaded to 0x5A at address 3 → a_gnt pulses cycle 1, mem_read=1 and mem_addr=0x03 in cycle 1, a_rvalid=1 and rdata=0x5A in cycle 2; b_gnt stays 0.
- B writes 0xC3 to 0x02, then A reads 0x02 → mem_write=1 only in the B issue cycle; A read returns rdata=0xC3.
- A and B both hold req for 8 cycles with reads to addresses 1 and 2 → grants A,B,A,B,...; each rvalid matches its owner with the correct data; mem_write and mem_read are never both 1.
- Assert rst=0 for one cycle while a read from B is in ISSUE → b_rvalid never asserts; all outputs are 0 during reset; the next A request after release wins immediately.
- With DMEM_ARB_LOCK_EN defined, B issues 3 locked writes (b_lock=1,1,0) while a_req=1 throughout → A receives no grant until after B's b_lock=0 grant, then a_gnt is asserted within 2 cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for the single-port
// data memory. Port A is the CPU load/store stage, port B the DMA/debug loader.
// One command is issued per cycle on registered memory outputs; read data is
// captured from the memory and returned to the issuing port with a strobe.
// Optional feature: define DMEM_ARB_LOCK_EN to add the b_lock input, which lets
// port B hold exclusive ownership across a sequence of grants.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DATA_DIR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_req,
  input  logic                      a_we,
  input  logic [DATA_DIR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]     a_wdata,
  output logic                      a_gnt,
  output logic                      a_rvalid,
  input  logic                      b_req,
  input  logic                      b_we,
  input  logic [DATA_DIR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]     b_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                      b_lock,
`endif
  output logic                      b_gnt,
  output logic                      b_rvalid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [DATA_DIR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_write,
  output logic                      mem_read,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_A = 2'd1,
    ISSUE_B = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      last_b_q, last_b_d;
  logic                      a_elig, b_elig, a_block;
  logic [DATA_DIR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]     wdata_d, rdata_d;
  logic                      write_d, read_d;
  logic                      a_rvalid_d, b_rvalid_d;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;

  // Lock follows b_lock on each B grant; an idle, non-granted B releases it
  always_comb begin
    lock_d = lock_q;
    if (state_d == ISSUE_B) begin
      lock_d = b_lock;
    end else if (!b_req && !b_gnt) begin
      lock_d = 1'b0;
    end
  end

  // Lock flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign a_block = lock_q;
`else
  assign a_block = 1'b0;
`endif

  // Arbitration, next issue state and next values of the registered outputs
  always_comb begin
    state_d    = IDLE;
    last_b_d   = last_b_q;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    write_d    = 1'b0;
    read_d     = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    rdata_d    = rdata;

    // A request is consumed during its gnt cycle, so it cannot win again then
    a_elig = a_req && !a_gnt && !a_block;
    b_elig = b_req && !b_gnt;

    if (a_elig && b_elig) begin
      if (last_b_q) begin
        state_d  = ISSUE_A;
        last_b_d = 1'b0;
      end else begin
        state_d  = ISSUE_B;
        last_b_d = 1'b1;
      end
    end else if (a_elig) begin
      state_d = ISSUE_A;
    end else if (b_elig) begin
      state_d = ISSUE_B;
    end

    case (state_d)
      ISSUE_A: begin
        addr_d  = a_addr;
        wdata_d = a_wdata;
        write_d = a_we;
        read_d  = !a_we;
      end
      ISSUE_B: begin
        addr_d  = b_addr;
        wdata_d = b_wdata;
        write_d = b_we;
        read_d  = !b_we;
      end
      default: ;
    endcase

    // Memory samples the read at the end of the issue cycle; return it to the issuer
    if (mem_read) begin
      rdata_d    = mem_rdata;
      a_rvalid_d = (state_q == ISSUE_A);
      b_rvalid_d = (state_q == ISSUE_B);
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      a_gnt     <= (state_d == ISSUE_A);
      b_gnt     <= (state_d == ISSUE_B);
      a_rvalid  <= a_rvalid_d;
      b_rvalid  <= b_rvalid_d;
      rdata     <= rdata_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_write <= write_d;
      mem_read  <= read_d;
    end
  end

endmodule
